run_control: RTL and testbench
==============================

RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive clk cycles a step_btn level must hold before it is accepted.
REQ-002 Parameter CYC_W, default 32: width of cycle_count.
REQ-003 Port clk  input  1  board clock, rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port slow_clk  input  1  divided clock from the clock divider, generated from clk.
REQ-006 Port step_btn  input  1  raw manual-step push-button, active-high, asynchronous.
REQ-007 Port mode_run  input  1  board switch: 1 = free-run, 0 = single-step.
REQ-008 Port halt_req  input  1  halt request from the CPU (break/syscall), level.
REQ-009 Port cpu_en  output  1  registered one-clk-cycle CPU clock-enable pulse.
REQ-010 Port state  output  2  current FSM state encoding.
REQ-011 Port halted  output  1  high while in HALT.
REQ-012 Port cycle_count  output  CYC_W  number of cpu_en pulses issued since reset.

Function
REQ-013 slow_clk SHALL be registered into slow_q; tick = slow_clk AND NOT slow_q.
REQ-014 The debounced step_btn level SHALL pass a 2-flop synchronizer, change only after DEBOUNCE_CYCLES stable samples, and produce step_press, a one-cycle pulse on its rising edge.
REQ-015 States SHALL be IDLE=00, RUN=01, STEP=10, HALT=11.
REQ-016 IDLE: halt_req -> HALT; else mode_run=1 -> RUN; else step_press -> STEP; else stay.
REQ-017 RUN: halt_req -> HALT; else mode_run=0 -> IDLE; else stay. On a tick with neither condition, cpu_en SHALL be 1 in the next clk cycle.
REQ-018 STEP: halt_req -> HALT with no pulse; else cpu_en SHALL be 1 for exactly the next cycle and the state returns to IDLE.
REQ-019 HALT: cpu_en SHALL stay 0; exit to IDLE only on step_press with mode_run=0.
REQ-020 halt_req SHALL take priority over tick, mode_run and step_press in the same cycle.
REQ-021 cpu_en SHALL never be high for two consecutive cycles.
REQ-022 cycle_count SHALL increment with each cpu_en pulse and saturate at all-ones, with no wrap.
REQ-023 A step_press while in RUN or STEP SHALL be ignored and not queued.

Reset
REQ-024 While rst=0 at a clk edge: state=IDLE, cpu_en=0, halted=0, cycle_count=0, slow_q=0, and the debouncer is cleared to level 0.
REQ-025 A reset asserted mid-RUN or mid-STEP SHALL suppress any pending cpu_en pulse.

Configuration
REQ-026 Macro RUN_CONTROL_CYCLE_COUNT_EN defined: cycle_count is implemented per REQ-022.
REQ-027 Macro RUN_CONTROL_CYCLE_COUNT_EN undefined: cycle_count is tied to 0, no counter logic is present, and all other behaviour is unchanged.

Structure
REQ-028 Package run_control_pkg SHALL hold the state typedef, the state encodings and the default parameter constants.
REQ-029 Debounce and edge detection SHALL live in sub-module btn_debounce (ports clk, rst, btn_in, level, press).

Verification (DEBOUNCE_CYCLES=4, CYC_W=4)
REQ-030 mode_run=1, slow_clk toggling every 8 clk -> exactly one cpu_en per slow_clk rising edge, one cycle after detection; cycle_count=3 after three edges.
REQ-031 mode_run=0, step_btn high for 10 clk -> exactly one cpu_en, with state IDLE->STEP->IDLE; a 2-clk glitch -> no pulse.
REQ-032 RUN, halt_req coincident with tick -> no cpu_en, state=11, halted=1; then step_press with mode_run=0 -> state=00.
REQ-033 RUN with 20 ticks -> cycle_count saturates at 15; with the macro undefined -> cycle_count stays 0.
REQ-034 rst=0 in the cycle a tick is detected in RUN -> cpu_en stays 0 and all outputs show reset values next cycle.

Source files
------------

// File: rtl/run_control_pkg.sv
// Shared types and defaults for the CPU run/step controller.
package run_control_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_e;

   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int CYC_W_DEF           = 32;

endpackage

// File: rtl/run_control_if.sv
// Board/CPU-side signal bundle of run_control; master drives the inputs, slave is the controller.
interface run_control_if
   import run_control_pkg::*;
#(
   parameter int CYC_W = CYC_W_DEF
) ();

   logic             slow_clk;
   logic             step_btn;
   logic             mode_run;
   logic             halt_req;
   logic             cpu_en;
   logic [1:0]       state;
   logic             halted;
   logic [CYC_W-1:0] cycle_count;

   modport master (
      output slow_clk, step_btn, mode_run, halt_req,
      input  cpu_en, state, halted, cycle_count
   );

   modport slave (
      input  slow_clk, step_btn, mode_run, halt_req,
      output cpu_en, state, halted, cycle_count
   );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, level accepted after DEBOUNCE_CYCLES stable samples.
// press pulses for one cycle in the same cycle level rises.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The run counter restarts whenever the synchronized input agrees with the accepted level.
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            press_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_in};
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/run_control.sv
// CPU clock-enable controller (free-run / single-step / halt); cpu_en is registered, one clk after the deciding event.
// Optional saturating pulse counter on cycle_count when RUN_CONTROL_CYCLE_COUNT_EN is defined.
module run_control
   import run_control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CYC_W           = CYC_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   run_control_if.slave  ctl
);

   logic   slow_q;
   logic   tick;
   logic   step_level;
   logic   step_press;
   logic   btn_evt;
   state_e state_q, state_d;
   logic   cpu_en_q, cpu_en_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_in (ctl.step_btn),
      .level  (step_level),
      .press  (step_press)
   );

   assign tick    = ctl.slow_clk & ~slow_q;
   assign btn_evt = step_press & step_level;

   // halt_req is tested first in every state so it dominates tick, mode and button.
   always_comb begin
      state_d  = state_q;
      cpu_en_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ctl.halt_req)      state_d = ST_HALT;
            else if (ctl.mode_run) state_d = ST_RUN;
            else if (btn_evt)      state_d = ST_STEP;
         end
         ST_RUN: begin
            if (ctl.halt_req)       state_d  = ST_HALT;
            else if (!ctl.mode_run) state_d  = ST_IDLE;
            else if (tick)          cpu_en_d = 1'b1;
         end
         ST_STEP: begin
            if (ctl.halt_req) begin
               state_d = ST_HALT;
            end else begin
               cpu_en_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_HALT: begin
            if (!ctl.halt_req && btn_evt && !ctl.mode_run) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (cpu_en_q) cpu_en_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         slow_q   <= 1'b0;
         state_q  <= ST_IDLE;
         cpu_en_q <= 1'b0;
      end else begin
         slow_q   <= ctl.slow_clk;
         state_q  <= state_d;
         cpu_en_q <= cpu_en_d;
      end
   end

   assign ctl.cpu_en = cpu_en_q;
   assign ctl.state  = state_q;
   assign ctl.halted = (state_q == ST_HALT);

`ifdef RUN_CONTROL_CYCLE_COUNT_EN
   logic [CYC_W-1:0] cnt_q, cnt_d;

   assign cnt_d = (cpu_en_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign ctl.cycle_count = cnt_q;
`else
   assign ctl.cycle_count = {CYC_W{1'b0}};
`endif

endmodule

// File: tb/tb_run_control.sv
// Randomized and directed bench for run_control against an event-level reference model.
module tb_run_control;

   localparam int DB = 4;
   localparam int CW = 4;
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_STEP = 2'b10;
   localparam logic [1:0] S_HALT = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   run_control_if #(.CYC_W(CW)) bus ();

   run_control #(
      .DEBOUNCE_CYCLES (DB),
      .CYC_W           (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ctl (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: button history, accepted level, pending press, mode, pending enable, pulses issued.
   logic       m_slow_prev;
   logic       m_hist[$];
   logic       m_lvl;
   logic       m_press;
   logic [1:0] m_st;
   logic       m_en;
   int         m_issued;

   function automatic logic [CW-1:0] exp_cnt();
`ifdef RUN_CONTROL_CYCLE_COUNT_EN
      return (m_issued >= (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(m_issued);
`else
      return '0;
`endif
   endfunction

   task automatic model_edge();
      logic       tick, stable, pr;
      logic [1:0] nst;
      logic       nen;
      if (!rst) begin
         m_slow_prev = 1'b0;
         m_hist.delete();
         for (int i = 0; i < DB + 2; i++) m_hist.push_back(1'b0);
         m_lvl = 1'b0; m_press = 1'b0; m_st = S_IDLE; m_en = 1'b0; m_issued = 0;
         return;
      end
      tick = bus.slow_clk && !m_slow_prev;
      pr   = m_press;
      nst  = m_st;
      nen  = 1'b0;
      if (bus.halt_req) nst = S_HALT;
      else begin
         case (m_st)
            S_IDLE:  nst = bus.mode_run ? S_RUN : (pr ? S_STEP : S_IDLE);
            S_RUN:   if (!bus.mode_run) nst = S_IDLE; else nen = tick;
            S_STEP:  begin nen = 1'b1; nst = S_IDLE; end
            default: if (pr && !bus.mode_run) nst = S_IDLE;
         endcase
      end
      if (m_en) m_issued++;
      // Button is seen two edges late; accept a new level once the last DB seen samples all disagree.
      m_hist.push_front(bus.step_btn);
      void'(m_hist.pop_back());
      stable = 1'b1;
      for (int i = 2; i < DB + 2; i++) if (m_hist[i] == m_lvl) stable = 1'b0;
      m_press = 1'b0;
      if (stable) begin
         m_lvl   = ~m_lvl;
         m_press = m_lvl;
      end
      m_slow_prev = bus.slow_clk;
      m_st = nst;
      m_en = nen;
   endtask

   task automatic tick_clk();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic slow, input logic btn, input logic mode, input logic halt);
      bus.slow_clk = slow; bus.step_btn = btn; bus.mode_run = mode; bus.halt_req = halt;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick_clk();
      tick_clk();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_clk();
         vectors++;
         if ({bus.state, bus.cpu_en, bus.halted, bus.cycle_count} !== {S_IDLE, 1'b0, 1'b0, CW'(0)}) begin
            miscompares++;
            $display("FAIL reset: state=%0d cpu_en=%0b halted=%0b cnt=%0d, expected all zero",
                     bus.state, bus.cpu_en, bus.halted, bus.cycle_count);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick_clk();
      rst = 1'b1;
   endtask

   task automatic test_free_run();
      int pulses = 0;
      int late   = 0;
      do_reset();
      for (int i = 0; i < 48; i++) begin
         drive(((i / 8) % 2) == 1, 1'b0, 1'b1, 1'b0);
         tick_clk();
         if (bus.cpu_en) pulses++;
         if (bus.cpu_en !== (i == 8 || i == 24 || i == 40)) late++;
         vectors++;
         if ({bus.state, bus.cpu_en, bus.cycle_count} !== {m_st, m_en, exp_cnt()}) begin
            miscompares++;
            $display("FAIL free_run cyc %0d: state=%0d en=%0b cnt=%0d, expected state=%0d en=%0b cnt=%0d",
                     i, bus.state, bus.cpu_en, bus.cycle_count, m_st, m_en, exp_cnt());
         end
      end
      vectors++;
      if (pulses != 3 || late != 0) begin
         miscompares++;
         $display("FAIL free_run_pulses: got %0d pulses (%0d misplaced), expected 3 (0 misplaced)", pulses, late);
      end
      vectors++;
`ifdef RUN_CONTROL_CYCLE_COUNT_EN
      if (bus.cycle_count !== CW'(3)) begin
`else
      if (bus.cycle_count !== CW'(0)) begin
`endif
         miscompares++;
         $display("FAIL free_run_count: cycle_count=%0d", bus.cycle_count);
      end
   endtask

   task automatic test_single_step();
      int pulses = 0;
      int seen_step = 0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         // 10-clk press, then a 2-clk glitch after a long release
         drive(1'b0, (i < 10) || (i == 28) || (i == 29), 1'b0, 1'b0);
         tick_clk();
         if (bus.cpu_en) pulses++;
         if (bus.state === S_STEP) seen_step++;
         vectors++;
         if ({bus.state, bus.cpu_en, bus.halted} !== {m_st, m_en, 1'b0}) begin
            miscompares++;
            $display("FAIL single_step cyc %0d: state=%0d en=%0b, expected state=%0d en=%0b",
                     i, bus.state, bus.cpu_en, m_st, m_en);
         end
      end
      vectors++;
      if (pulses != 1 || seen_step != 1 || bus.state !== S_IDLE) begin
         miscompares++;
         $display("FAIL single_step_summary: pulses=%0d step_cycles=%0d final=%0d, expected 1 1 0",
                  pulses, seen_step, bus.state);
      end
   endtask

   task automatic test_halt();
      int pulses = 0;
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick_clk();
      tick_clk();
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      tick_clk();
      vectors++;
      if ({bus.state, bus.halted, bus.cpu_en} !== {S_HALT, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL halt_on_tick: state=%0d halted=%0b en=%0b, expected 3 1 0",
                  bus.state, bus.halted, bus.cpu_en);
      end
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, (i >= 4 && i < 14), 1'b0, 1'b0);
         tick_clk();
         if (bus.cpu_en) pulses++;
         vectors++;
         if ({bus.state, bus.halted, bus.cpu_en} !== {m_st, m_st == S_HALT, m_en}) begin
            miscompares++;
            $display("FAIL halt_exit cyc %0d: state=%0d halted=%0b en=%0b, expected state=%0d",
                     i, bus.state, bus.halted, bus.cpu_en, m_st);
         end
      end
      vectors++;
      if (pulses != 0 || bus.state !== S_IDLE) begin
         miscompares++;
         $display("FAIL halt_release: pulses=%0d state=%0d, expected 0 0", pulses, bus.state);
      end
   endtask

   task automatic test_saturate();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 86; i++) begin
         drive(((i / 2) % 2) == 1 && i < 82, 1'b0, 1'b1, 1'b0);
         tick_clk();
         if (bus.cpu_en) pulses++;
         vectors++;
         if ({bus.cpu_en, bus.cycle_count} !== {m_en, exp_cnt()}) begin
            miscompares++;
            $display("FAIL saturate cyc %0d: en=%0b cnt=%0d, expected en=%0b cnt=%0d",
                     i, bus.cpu_en, bus.cycle_count, m_en, exp_cnt());
         end
      end
      vectors++;
`ifdef RUN_CONTROL_CYCLE_COUNT_EN
      if (pulses != 20 || bus.cycle_count !== CW'(15)) begin
`else
      if (pulses != 20 || bus.cycle_count !== CW'(0)) begin
`endif
         miscompares++;
         $display("FAIL saturate_final: pulses=%0d cnt=%0d", pulses, bus.cycle_count);
      end
   endtask

   task automatic test_reset_on_tick();
      int pulses = 0;
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick_clk();
      tick_clk();
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      tick_clk();
      vectors++;
      if ({bus.state, bus.cpu_en, bus.halted, bus.cycle_count} !== {S_IDLE, 1'b0, 1'b0, CW'(0)}) begin
         miscompares++;
         $display("FAIL reset_on_tick: state=%0d en=%0b halted=%0b cnt=%0d, expected all zero",
                  bus.state, bus.cpu_en, bus.halted, bus.cycle_count);
      end
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick_clk();
         if (bus.cpu_en) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL reset_on_tick_pending: %0d pulses after reset, expected 0", pulses);
      end
   endtask

   task automatic test_random();
      logic prev_en = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(199) != 0);
         if ($urandom_range(3) == 0)  bus.slow_clk = ~bus.slow_clk;
         if ($urandom_range(7) == 0)  bus.step_btn = ~bus.step_btn;
         if ($urandom_range(39) == 0) bus.mode_run = ~bus.mode_run;
         bus.halt_req = ($urandom_range(29) == 0);
         tick_clk();
         vectors++;
         if ({bus.state, bus.cpu_en, bus.halted, bus.cycle_count} !==
             {m_st, m_en, m_st == S_HALT, exp_cnt()} || (prev_en && bus.cpu_en)) begin
            miscompares++;
            $display("FAIL random cyc %0d: state=%0d en=%0b halted=%0b cnt=%0d, expected state=%0d en=%0b cnt=%0d",
                     i, bus.state, bus.cpu_en, bus.halted, bus.cycle_count, m_st, m_en, exp_cnt());
         end
         prev_en = bus.cpu_en;
      end
      rst = 1'b1;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_free_run();
      test_single_step();
      test_halt();
      test_saturate();
      test_reset_on_tick();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
